// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Multicycle control FSM for a MIPS-subset datapath. Each instruction passes
// through FETCH -> DECODE -> EXEC [-> MEM] [-> WB]. The opcode and funct
// fields are captured as the FSM leaves S_FETCH. All datapath controls are
// Moore outputs decoded from the state register and the captured fields.
// ALU_zero only qualifies PC_LdEn for beq. Mem_ack only moves S_MEM forward.
//
// Memory handshake (valid/ready): Mem_req acts as valid and Mem_ack as ready.
// Mem_req and Mem_WrEn are held constant from entry to S_MEM until the cycle in
// which Mem_ack is sampled high. That cycle completes the transfer. Mem_ack
// seen in any other state is ignored.
//
// Optional feature: define MIPS_CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes.
// With the macro, S_TRAP drives Illegal_op high and holds every other output
// low until Rst_n. Without it, an unknown opcode is a NOP that returns to
// S_FETCH straight from S_DECODE.
//
// Ports:
//   Clk, Rst_n          clock, asynchronous active-low reset
//   Instr               instruction word (sampled while in S_FETCH)
//   ALU_zero            ALU zero flag (beq in S_EXEC)
//   Mem_ack             data memory completion pulse
//   Instr_LdEn, PC_LdEn, PC_sel          fetch / PC controls
//   RF_B_sel, RF_WrData_sel, RF_WrEn      register file controls
//   ALU_Bin_sel, ALU_func                 ALU controls
//   Mem_req, Mem_WrEn                     data memory request
//   Busy                high in DECODE/EXEC/MEM/WB
//   Illegal_op          (macro only) sticky illegal-opcode flag
//   state_dbg           current FSM state encoding
module mips_multicycle_ctrl #(
   parameter int OP_W   = 6,
   parameter int ALUF_W = 4
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic [31:0]       Instr,
   input  logic              ALU_zero,
   input  logic              Mem_ack,
   output logic              Instr_LdEn,
   output logic              PC_LdEn,
   output logic [1:0]        PC_sel,
   output logic              RF_B_sel,
   output logic              RF_WrData_sel,
   output logic              RF_WrEn,
   output logic              ALU_Bin_sel,
   output logic [ALUF_W-1:0] ALU_func,
   output logic              Mem_req,
   output logic              Mem_WrEn,
   output logic              Busy,
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
   output logic              Illegal_op,
`endif
   output logic [2:0]        state_dbg
);

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
   localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;

   localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
   localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
   localparam logic [OP_W-1:0] FN_AND = 6'b100100;
   localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
   localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

   localparam logic [ALUF_W-1:0] ALU_ADD = 4'b0000;
   localparam logic [ALUF_W-1:0] ALU_SUB = 4'b0001;
   localparam logic [ALUF_W-1:0] ALU_AND = 4'b0010;
   localparam logic [ALUF_W-1:0] ALU_OR  = 4'b0011;
   localparam logic [ALUF_W-1:0] ALU_SLT = 4'b0100;

   state_t            state, state_next;
   logic [OP_W-1:0]   op_q, funct_q;
   logic [ALUF_W-1:0] alu_f;
   logic              alu_imm;
   logic              op_known;
   logic              is_lw, is_sw, is_beq, is_j, is_mem;

   // The register and immediate fields go straight to the datapath.
   logic unused_instr_bits;
   assign unused_instr_bits = ^Instr[31-OP_W:OP_W];

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state   <= S_RESET;
         op_q    <= '0;
         funct_q <= '0;
      end else begin
         state <= state_next;
         if (state == S_FETCH) begin
            op_q    <= Instr[31 -: OP_W];
            funct_q <= Instr[OP_W-1:0];
         end
      end
   end

   assign is_lw  = (op_q == OP_LW);
   assign is_sw  = (op_q == OP_SW);
   assign is_beq = (op_q == OP_BEQ);
   assign is_j   = (op_q == OP_J);
   assign is_mem = is_lw | is_sw;

   // ALU decode from the captured fields; used in EXEC and held through MEM.
   always_comb begin
      alu_f    = ALU_ADD;
      alu_imm  = 1'b0;
      op_known = 1'b1;
      case (op_q)
         OP_RTYPE: begin
            case (funct_q)
               FN_SUB:  alu_f = ALU_SUB;
               FN_AND:  alu_f = ALU_AND;
               FN_OR:   alu_f = ALU_OR;
               FN_SLT:  alu_f = ALU_SLT;
               FN_ADD:  alu_f = ALU_ADD;
               default: alu_f = ALU_ADD;
            endcase
         end
         OP_ADDI, OP_LW, OP_SW: alu_imm = 1'b1;
         OP_ANDI: begin
            alu_f   = ALU_AND;
            alu_imm = 1'b1;
         end
         OP_ORI: begin
            alu_f   = ALU_OR;
            alu_imm = 1'b1;
         end
         OP_BEQ:  alu_f = ALU_SUB;
         OP_J:    alu_f = ALU_ADD;
         default: op_known = 1'b0;
      endcase
   end

   always_comb begin
      state_next    = S_RESET;
      Instr_LdEn    = 1'b0;
      PC_LdEn       = 1'b0;
      PC_sel        = 2'd0;
      RF_B_sel      = 1'b0;
      RF_WrData_sel = 1'b0;
      RF_WrEn       = 1'b0;
      ALU_Bin_sel   = 1'b0;
      ALU_func      = '0;
      Mem_req       = 1'b0;
      Mem_WrEn      = 1'b0;
      Busy          = 1'b0;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      Illegal_op    = 1'b0;
`endif
      case (state)
         S_RESET: state_next = S_FETCH;
         S_FETCH: begin
            Instr_LdEn = 1'b1;
            PC_LdEn    = 1'b1;
            state_next = S_DECODE;
         end
         S_DECODE: begin
            Busy     = 1'b1;
            // sw and beq read rt (Instr[20:16]) on port B.
            RF_B_sel = is_sw | is_beq;
            if (op_known)
               state_next = S_EXEC;
            else
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
               state_next = S_TRAP;
`else
               state_next = S_FETCH;
`endif
         end
         S_EXEC: begin
            Busy        = 1'b1;
            ALU_func    = alu_f;
            ALU_Bin_sel = alu_imm;
            if (is_beq) begin
               PC_sel     = 2'd1;
               PC_LdEn    = ALU_zero;
               state_next = S_FETCH;
            end else if (is_j) begin
               PC_sel     = 2'd2;
               PC_LdEn    = 1'b1;
               state_next = S_FETCH;
            end else if (is_mem) begin
               state_next = S_MEM;
            end else begin
               state_next = S_WB;
            end
         end
         S_MEM: begin
            Busy        = 1'b1;
            Mem_req     = 1'b1;
            Mem_WrEn    = is_sw;
            ALU_func    = alu_f;
            ALU_Bin_sel = alu_imm;
            if (Mem_ack)
               state_next = is_lw ? S_WB : S_FETCH;
            else
               state_next = S_MEM;
         end
         S_WB: begin
            Busy          = 1'b1;
            RF_WrEn       = 1'b1;
            RF_WrData_sel = is_lw;
            state_next    = S_FETCH;
         end
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
         S_TRAP: begin
            Illegal_op = 1'b1;
            state_next = S_TRAP;
         end
`endif
         default: state_next = S_RESET;
      endcase
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl. A reference model of the control
// sequence pushes one expected control word per cycle into exp_q before an
// instruction is driven. Each cycle pops one word and compares it with the
// DUT outputs at the falling edge.
module tb_mips_multicycle_ctrl;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic [31:0] Instr;
   logic        ALU_zero;
   logic        Mem_ack;
   logic        Instr_LdEn, PC_LdEn, RF_B_sel, RF_WrData_sel, RF_WrEn;
   logic        ALU_Bin_sel, Mem_req, Mem_WrEn, Busy;
   logic [1:0]  PC_sel;
   logic [3:0]  ALU_func;
   logic [2:0]  state_dbg;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
   logic        Illegal_op;
`endif

   int checks = 0;
   int errors = 0;
   int busy_cnt;
   logic [14:0] exp_q[$];
   logic [14:0] act;

   always #5 Clk = ~Clk;

   mips_multicycle_ctrl dut (
      .Clk(Clk), .Rst_n(Rst_n), .Instr(Instr), .ALU_zero(ALU_zero), .Mem_ack(Mem_ack),
      .Instr_LdEn(Instr_LdEn), .PC_LdEn(PC_LdEn), .PC_sel(PC_sel), .RF_B_sel(RF_B_sel),
      .RF_WrData_sel(RF_WrData_sel), .RF_WrEn(RF_WrEn), .ALU_Bin_sel(ALU_Bin_sel),
      .ALU_func(ALU_func), .Mem_req(Mem_req), .Mem_WrEn(Mem_WrEn), .Busy(Busy),
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      .Illegal_op(Illegal_op),
`endif
      .state_dbg(state_dbg)
   );

   assign act = {Instr_LdEn, PC_LdEn, PC_sel, RF_B_sel, RF_WrData_sel, RF_WrEn,
                 ALU_Bin_sel, ALU_func, Mem_req, Mem_WrEn, Busy};

   function automatic logic [14:0] cw(logic il, logic pl, logic [1:0] ps, logic bs,
                                      logic wds, logic wr, logic bin, logic [3:0] f,
                                      logic mr, logic mw, logic busy);
      return {il, pl, ps, bs, wds, wr, bin, f, mr, mw, busy};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive Mem_ack, compare outputs with the scoreboard head.
   task automatic step(input logic ack, input string tag);
      logic [14:0] e;
      Mem_ack = ack;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s observed=%0h expected=empty_queue", tag, act);
      end else begin
         e = exp_q.pop_front();
         check(tag, {17'd0, act}, {17'd0, e});
      end
      check({tag, "_wr_req_excl"}, {31'd0, RF_WrEn & Mem_req}, 32'd0);
      busy_cnt += int'(Busy);
      @(posedge Clk);
      @(negedge Clk);
   endtask

   // Reference sequence for one instruction; returns cycle count and ack cycle.
   task automatic push_instr(input logic [31:0] ins, input logic zero, input int w,
                             output int n, output int ack_at, output int lat);
      logic [5:0] op, fn;
      logic [3:0] f;
      logic is_r, is_imm, is_lw, is_sw, is_beq, is_j, bin;
      int start;
      start  = exp_q.size();
      op     = ins[31:26];
      fn     = ins[5:0];
      is_r   = (op == 6'b000000);
      is_imm = (op == 6'b001000) || (op == 6'b001100) || (op == 6'b001101);
      is_lw  = (op == 6'b100011);
      is_sw  = (op == 6'b101011);
      is_beq = (op == 6'b000100);
      is_j   = (op == 6'b000010);
      f = 4'b0000;
      if (is_r) begin
         case (fn)
            6'b100010: f = 4'b0001;
            6'b100100: f = 4'b0010;
            6'b100101: f = 4'b0011;
            6'b101010: f = 4'b0100;
            default:   f = 4'b0000;
         endcase
      end
      if (op == 6'b001100) f = 4'b0010;
      if (op == 6'b001101) f = 4'b0011;
      if (is_beq) f = 4'b0001;
      bin    = is_imm | is_lw | is_sw;
      ack_at = -1;
      exp_q.push_back(cw(1, 1, 2'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0));
      exp_q.push_back(cw(0, 0, 2'd0, is_sw | is_beq, 0, 0, 0, 4'd0, 0, 0, 1));
      if (is_r | is_imm | is_lw | is_sw | is_beq | is_j) begin
         exp_q.push_back(cw(0, is_beq ? zero : is_j, is_beq ? 2'd1 : (is_j ? 2'd2 : 2'd0),
                            0, 0, 0, bin, f, 0, 0, 1));
         if (is_lw | is_sw) begin
            for (int k = 0; k <= w; k++)
               exp_q.push_back(cw(0, 0, 2'd0, 0, 0, 0, bin, f, 1, is_sw, 1));
            ack_at = 3 + w;
         end
         if (is_lw | is_r | is_imm)
            exp_q.push_back(cw(0, 0, 2'd0, 0, is_lw, 1, 0, 4'd0, 0, 0, 1));
      end
      n = exp_q.size() - start;
      // Latency as stated for each instruction class.
      if (is_beq | is_j)      lat = 3;
      else if (is_r | is_imm) lat = 4;
      else if (is_sw)         lat = 4 + w;
      else if (is_lw)         lat = 5 + w;
      else                    lat = 2;
   endtask

   task automatic run_instr(input logic [31:0] ins, input logic zero, input int w,
                            input logic stray, input string tag);
      int n, ack_at, lat;
      Instr    = ins;
      ALU_zero = zero;
      push_instr(ins, zero, w, n, ack_at, lat);
      busy_cnt = 0;
      for (int i = 0; i < n; i++)
         step((i == ack_at) || (stray && (i == 1 || i == 2)), tag);
      check({tag, "_latency"}, busy_cnt + 1, lat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, ack_at, lat;
      Rst_n = 1'b0; Instr = '0; ALU_zero = 1'b0; Mem_ack = 1'b0;
      @(negedge Clk);
      check("reset_outputs", {17'd0, act}, 32'd0);
      check("reset_state", {29'd0, state_dbg}, 32'd0);
      Rst_n = 1'b1;
      exp_q.push_back(15'd0);
      step(1'b0, "s_reset");

      run_instr(32'h00221820, 1'b0, 0, 1'b0, "add");
      run_instr(32'h00221822, 1'b0, 0, 1'b0, "sub");
      run_instr(32'h00221824, 1'b0, 0, 1'b0, "and");
      run_instr(32'h00221825, 1'b0, 0, 1'b0, "or");
      run_instr(32'h0022182A, 1'b0, 0, 1'b0, "slt");
      run_instr(32'h00221827, 1'b0, 0, 1'b1, "rtype_other_stray_ack");
      run_instr(32'h20010005, 1'b0, 0, 1'b0, "addi");
      run_instr(32'h3001000F, 1'b0, 0, 1'b0, "andi");
      run_instr(32'h8C220004, 1'b0, 3, 1'b0, "lw_w3");
      run_instr(32'h8C220004, 1'b0, 0, 1'b1, "lw_w0");
      run_instr(32'hAC220004, 1'b0, 2, 1'b0, "sw_w2");
      run_instr(32'hAC220004, 1'b0, 0, 1'b0, "sw_w0");
      run_instr(32'h10220003, 1'b1, 0, 1'b0, "beq_taken");
      run_instr(32'h10220003, 1'b0, 0, 1'b0, "beq_not_taken");
      run_instr(32'h08000010, 1'b0, 0, 1'b0, "j");
      run_instr(32'h34010003, 1'b0, 0, 1'b0, "ori_after_j");
      for (int r = 0; r < 4; r++) begin
         run_instr(32'h8C220004, 1'b0, int'($urandom_range(0, 5)), 1'b0, "lw_rand");
         run_instr(32'hAC220004, 1'b0, int'($urandom_range(0, 5)), 1'b0, "sw_rand");
      end

      // sw interrupted by reset while waiting in S_MEM.
      Instr = 32'hAC220004;
      push_instr(Instr, 1'b0, 3, n, ack_at, lat);
      for (int i = 0; i < 5; i++) step(1'b0, "sw_pre_reset");
      exp_q.delete();
      #1 Rst_n = 1'b0;
      #1;
      check("rst_mem_req", {31'd0, Mem_req}, 32'd0);
      check("rst_state", {29'd0, state_dbg}, 32'd0);
      check("rst_outputs", {17'd0, act}, 32'd0);
      #1 Rst_n = 1'b1;
      Mem_ack = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      check("stray_ack_state", {29'd0, state_dbg}, 32'd1);
      run_instr(32'h00221820, 1'b0, 0, 1'b0, "add_after_reset");

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      Instr = 32'hFC000000;
      exp_q.push_back(cw(1, 1, 2'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0));
      exp_q.push_back(cw(0, 0, 2'd0, 0, 0, 0, 0, 4'd0, 0, 0, 1));
      step(1'b0, "illegal_fetch");
      step(1'b0, "illegal_decode");
      for (int i = 0; i < 3; i++) begin
         check("trap_flag", {31'd0, Illegal_op}, 32'd1);
         check("trap_outputs", {17'd0, act}, 32'd0);
         @(negedge Clk);
      end
      Rst_n = 1'b0;
      #1 check("trap_reset_flag", {31'd0, Illegal_op}, 32'd0);
      @(negedge Clk);
      Rst_n = 1'b1;
      exp_q.push_back(15'd0);
      step(1'b0, "s_reset_after_trap");
`else
      run_instr(32'hFC000000, 1'b0, 0, 1'b0, "illegal_nop");
`endif
      run_instr(32'h00221822, 1'b0, 0, 1'b0, "sub_final");

      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
